blockram_port_arbiter: RTL and testbench
========================================

// Module: blockram_port_arbiter
// PURPOSE
//  Shares one port of dual_port_blockram (WriteFirst, valid array on) among NUM_REQUESTER clients.
//  Round-robin grant, valid/ready request handshake, single outstanding access, response tagged
//  with requester id and held under backpressure. Sits between cache/queue clients and the RAM port.
// PARAMETERS
//  NUM_REQUESTER               4                           number of clients, >=2
//  SINGLE_ENTRY_WIDTH_IN_BITS  64                          RAM entry width
//  NUM_SET                     64                          RAM depth
//  SET_PTR_WIDTH_IN_BITS       $clog2(NUM_SET)             set address width
//  WRITE_MASK_LEN              SINGLE_ENTRY_WIDTH_IN_BITS/`BYTE_LEN_IN_BITS   byte-enable width
//  REQUESTER_ID_WIDTH          $clog2(NUM_REQUESTER)       response id width
// PORTS
//  clk_in                   in   1                    clock, single domain
//  reset_in                 in   1                    synchronous, active-high reset
//  request_valid_in         in   NUM_REQUESTER        per-client request valid
//  request_write_en_in      in   NUM_REQUESTER*WRITE_MASK_LEN   flattened byte masks, client i at [i*WML +: WML]
//  request_set_addr_in      in   NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS   flattened set addresses
//  request_write_entry_in   in   NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS   flattened write data
//  request_ready_out        out  NUM_REQUESTER        one-hot grant; transfer when valid&ready
//  ram_access_en_out        out  1                    to RAM port access_en
//  ram_write_en_out         out  WRITE_MASK_LEN       to RAM port write_en
//  ram_set_addr_out         out  SET_PTR_WIDTH_IN_BITS  to RAM port set addr
//  ram_write_entry_out      out  SINGLE_ENTRY_WIDTH_IN_BITS  to RAM port write data
//  ram_read_entry_in        in   SINGLE_ENTRY_WIDTH_IN_BITS  from RAM port read data
//  ram_read_valid_in        in   1                    from RAM port read valid
//  response_valid_out       out  1                    response pending
//  response_id_out          out  REQUESTER_ID_WIDTH   client that issued the access
//  response_is_write_out    out  1                    1 = access had nonzero write mask
//  response_entry_out       out  SINGLE_ENTRY_WIDTH_IN_BITS  = ram_read_entry_in while valid
//  response_entry_valid_out out  1                    = ram_read_valid_in while valid
//  response_ready_in        in   1                    consumer accepts response
// BEHAVIOUR
//  - Reset: rr_ptr=0, response_valid_out=0, response_id_out=0, response_is_write_out=0;
//    request_ready_out=0 and ram_access_en_out=0 in reset cycle. Reset mid-access drops response.
//  - issue_ok = ~response_valid_out | response_ready_in (same-cycle drain-and-issue allowed).
//  - Grant (combinational): first i with request_valid_in[i], scanning rr_ptr, rr_ptr+1 .. mod N.
//    request_ready_out[i]=1 only for granted i and only when issue_ok; else all 0.
//  - ram_access_en_out = |(request_valid_in & request_ready_out); RAM outs mux granted client's
//    fields; when no grant, ram_write_en_out=0, addr/data don't-care.
//  - On grant of i at cycle T: rr_ptr<=(i+1) mod N; response_valid_out<=1, response_id_out<=i,
//    response_is_write_out<=|mask at edge ending T. RAM data appears cycle T+1; response latency 1.
//  - Response held stable while response_valid_out & ~response_ready_in: no grants, so RAM
//    read register (updates only on access_en) holds. Accept w/o new grant -> response_valid_out<=0.
//  - Write response carries RAM WriteFirst data (masked write data); is_write=1.
//  - rr_ptr unchanged on cycles with no grant. Throughput 1 access/cycle if response_ready_in=1.
//  - Request fields must stay stable while valid & ~ready (client obligation; checked by SVA).
//  - Other RAM port is not touched; cross-port conflicts resolved by RAM (port-A priority).
// TESTING (N=4, 64b, 64 sets)
//  1 Reset: reset_in=1 with all valid=1 -> ready=0, access_en=0, response_valid=0.
//  2 Client 2 writes 0x1122334455667788 set 5 mask 0xFF, then reads set 5 -> read response
//    id=2, entry=0x1122334455667788, entry_valid=1, one cycle after grant.
//  3 All 4 valid continuously, response_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
//  4 response_ready=0 for 3 cycles after grant -> response fields stable, ready=0 all, no access_en.
//  5 Valid only on 3 with rr_ptr=1 -> grant 3 immediately, rr_ptr becomes 0.
//  6 Reset asserted cycle after grant -> response_valid=0 next cycle, rr_ptr=0, no stale response.

Source files
------------

// File: rtl/blockram_port_arbiter.sv
// blockram_port_arbiter
//   Shares a single port of a WriteFirst block RAM among NUM_REQUESTER clients.
//   Clients present valid/ready requests; one is granted per cycle in round-robin
//   order. Only one access is outstanding at a time: the response register holds
//   the id and access kind of the last grant, and the RAM read register (which only
//   updates on access_en) provides the data one cycle after the grant.
//
//   Ports
//     clk_in, reset_in              clock, synchronous active-high reset
//     request_*_in                  flattened per-client request fields
//     request_ready_out             one-hot grant, transfer on valid & ready
//     ram_*_out / ram_read_*_in     connection to the RAM port
//     response_*_out                tagged response, held while ~response_ready_in
//     response_ready_in             consumer accepts the pending response
module blockram_port_arbiter #(
  parameter int NUM_REQUESTER              = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / 8,
  parameter int REQUESTER_ID_WIDTH         = $clog2(NUM_REQUESTER)
) (
  input  logic                                            clk_in,
  input  logic                                            reset_in,
  input  logic [NUM_REQUESTER-1:0]                        request_valid_in,
  input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]         request_write_en_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]  request_set_addr_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_write_entry_in,
  output logic [NUM_REQUESTER-1:0]                        request_ready_out,
  output logic                                            ram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                       ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                ram_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           ram_write_entry_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           ram_read_entry_in,
  input  logic                                            ram_read_valid_in,
  output logic                                            response_valid_out,
  output logic [REQUESTER_ID_WIDTH-1:0]                   response_id_out,
  output logic                                            response_is_write_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]           response_entry_out,
  output logic                                            response_entry_valid_out,
  input  logic                                            response_ready_in
);

  localparam int WML = WRITE_MASK_LEN;
  localparam int AW  = SET_PTR_WIDTH_IN_BITS;
  localparam int EW  = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int IDW = REQUESTER_ID_WIDTH;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           issue_ok;
  logic           grant_en;
  logic [WML-1:0] grant_mask;

  // A pending response may be drained in the same cycle a new access issues.
  assign issue_ok = ~response_valid_out | response_ready_in;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQUESTER.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQUESTER; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQUESTER;
      if (!grant_found && request_valid_in[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant_en = grant_found & issue_ok & ~reset_in;

  always_comb begin
    request_ready_out = '0;
    if (grant_en) request_ready_out[grant_idx] = 1'b1;
  end

  assign grant_mask          = request_write_en_in[grant_idx*WML +: WML];
  assign ram_access_en_out   = |(request_valid_in & request_ready_out);
  assign ram_write_en_out    = grant_en ? grant_mask : '0;
  assign ram_set_addr_out    = request_set_addr_in[grant_idx*AW +: AW];
  assign ram_write_entry_out = request_write_entry_in[grant_idx*EW +: EW];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rr_ptr                <= '0;
      response_valid_out    <= 1'b0;
      response_id_out       <= '0;
      response_is_write_out <= 1'b0;
    end else if (grant_en) begin
      if (int'(grant_idx) == NUM_REQUESTER - 1) rr_ptr <= '0;
      else                                      rr_ptr <= grant_idx + 1'b1;
      response_valid_out    <= 1'b1;
      response_id_out       <= grant_idx;
      response_is_write_out <= |grant_mask;
    end else if (response_ready_in) begin
      response_valid_out    <= 1'b0;
    end
  end

  // The RAM read register only moves on access_en, and no access issues while a
  // response is stalled, so the RAM outputs double as the held response data.
  assign response_entry_out       = ram_read_entry_in;
  assign response_entry_valid_out = ram_read_valid_in & response_valid_out;

  // Clients must hold their request fields until the request is accepted.
  for (genvar i = 0; i < NUM_REQUESTER; i++) begin : g_req_stable
    a_req_stable : assert property (@(posedge clk_in)
      (!reset_in && request_valid_in[i] && !request_ready_out[i]) |=>
      (reset_in || !request_valid_in[i] ||
       ($stable(request_write_en_in[i*WML +: WML]) &&
        $stable(request_set_addr_in[i*AW +: AW]) &&
        $stable(request_write_entry_in[i*EW +: EW]))));
  end

endmodule

// File: tb/tb_blockram_port_arbiter.sv
// Testbench for blockram_port_arbiter: directed scenarios plus a randomized run
// against a scoreboard model, with a behavioural WriteFirst RAM on the port.
module tb_blockram_port_arbiter;

  localparam int N   = 4;
  localparam int EW  = 64;
  localparam int NS  = 64;
  localparam int AW  = 6;
  localparam int WML = 8;
  localparam int IDW = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                reset_in;
  logic [N-1:0]        req_v;
  logic [WML-1:0]      req_mask [N];
  logic [AW-1:0]       req_addr [N];
  logic [EW-1:0]       req_data [N];
  logic [N*WML-1:0]    req_mask_flat;
  logic [N*AW-1:0]     req_addr_flat;
  logic [N*EW-1:0]     req_data_flat;
  logic [N-1:0]        ready;
  logic                ram_access_en;
  logic [WML-1:0]      ram_we;
  logic [AW-1:0]       ram_addr;
  logic [EW-1:0]       ram_wdata;
  logic [EW-1:0]       ram_rd;
  logic                ram_rd_vld;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic                resp_isw;
  logic [EW-1:0]       resp_entry;
  logic                resp_ev;
  logic                resp_ready;

  int total = 0;
  int bad   = 0;

  always_comb begin
    req_mask_flat = '0;
    req_addr_flat = '0;
    req_data_flat = '0;
    for (int i = 0; i < N; i++) begin
      req_mask_flat[i*WML +: WML] = req_mask[i];
      req_addr_flat[i*AW +: AW]   = req_addr[i];
      req_data_flat[i*EW +: EW]   = req_data[i];
    end
  end

  blockram_port_arbiter #(
    .NUM_REQUESTER(N), .SINGLE_ENTRY_WIDTH_IN_BITS(EW), .NUM_SET(NS)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_valid_in(req_v), .request_write_en_in(req_mask_flat),
    .request_set_addr_in(req_addr_flat), .request_write_entry_in(req_data_flat),
    .request_ready_out(ready), .ram_access_en_out(ram_access_en),
    .ram_write_en_out(ram_we), .ram_set_addr_out(ram_addr),
    .ram_write_entry_out(ram_wdata), .ram_read_entry_in(ram_rd),
    .ram_read_valid_in(ram_rd_vld), .response_valid_out(resp_valid),
    .response_id_out(resp_id), .response_is_write_out(resp_isw),
    .response_entry_out(resp_entry), .response_entry_valid_out(resp_ev),
    .response_ready_in(resp_ready)
  );

  // Behavioural WriteFirst RAM port with a per-set valid bit.
  logic [EW-1:0] ram_mem [NS];
  logic          ram_vld [NS];
  logic [EW-1:0] ram_next;
  initial begin
    for (int s = 0; s < NS; s++) begin ram_mem[s] = '0; ram_vld[s] = 1'b0; end
    ram_rd = '0; ram_rd_vld = 1'b0;
  end
  always @(posedge clk_in) begin
    if (ram_access_en) begin
      ram_next = ram_mem[ram_addr];
      for (int b = 0; b < WML; b++)
        if (ram_we[b]) ram_next[b*8 +: 8] = ram_wdata[b*8 +: 8];
      if (|ram_we) begin
        ram_mem[ram_addr] <= ram_next;
        ram_vld[ram_addr] <= 1'b1;
      end
      ram_rd     <= ram_next;
      ram_rd_vld <= (|ram_we) ? 1'b1 : ram_vld[ram_addr];
    end
  end

  // Scoreboard model: pointer, pending response and a shadow of RAM contents.
  int            m_ptr = 0;
  bit            m_rv  = 1'b0;
  logic [IDW-1:0] m_id = '0;
  bit            m_isw = 1'b0;
  logic [EW-1:0] m_entry = '0;
  bit            m_ev  = 1'b0;
  logic [EW-1:0] sh_mem [NS];
  bit            sh_vld [NS];
  initial for (int s = 0; s < NS; s++) begin sh_mem[s] = '0; sh_vld[s] = 1'b0; end

  function automatic int model_grant();
    if (reset_in) return -1;
    if (m_rv && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (req_v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (reset_in) begin
      m_ptr = 0; m_rv = 0; m_id = '0; m_isw = 0;
    end else if (g >= 0) begin
      int a;
      a = int'(req_addr[g]);
      if (req_mask[g] != 0) begin
        for (int j = 0; j < EW; j++)
          if (req_mask[g][j/8]) sh_mem[a][j] = req_data[g][j];
        sh_vld[a] = 1'b1;
      end
      m_ptr   = (g + 1) % N;
      m_rv    = 1'b1;
      m_id    = g[IDW-1:0];
      m_isw   = (req_mask[g] != 0);
      m_entry = sh_mem[a];
      m_ev    = sh_vld[a];
    end else if (resp_ready) begin
      m_rv = 1'b0;
    end
  endtask

  task automatic tick(output int g);
    g = model_grant();
    @(posedge clk_in);
    model_update(g);
    #1;
  endtask

  task automatic test_reset();
    int g;
    reset_in = 1'b1; resp_ready = 1'b1; req_v = '1;
    for (int i = 0; i < N; i++) begin
      req_mask[i] = 8'hFF; req_addr[i] = AW'(i); req_data[i] = {$urandom, $urandom};
    end
    tick(g);
    @(negedge clk_in);
    total++; if (ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", ready); end
    total++; if (ram_access_en !== 1'b0) begin bad++; $display("FAIL reset_access_en got=%b want=0", ram_access_en); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    tick(g);
    reset_in = 1'b0; req_v = '0;
  endtask

  task automatic test_write_read();
    int g;
    req_v = 4'b0100; req_mask[2] = 8'hFF; req_addr[2] = 6'd5; req_data[2] = 64'h1122334455667788;
    @(negedge clk_in);
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL wr_ready got=%b want=0100", ready); end
    total++; if (ram_we !== 8'hFF || ram_addr !== 6'd5 || ram_wdata !== 64'h1122334455667788) begin
      bad++; $display("FAIL wr_ram_fields got we=%h addr=%0d data=%h want FF 5 1122334455667788", ram_we, ram_addr, ram_wdata); end
    tick(g);
    req_mask[2] = 8'h00;
    @(negedge clk_in);
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL rd_ready got=%b want=0100", ready); end
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_isw !== 1'b1 || resp_entry !== 64'h1122334455667788) begin
      bad++; $display("FAIL wr_resp got v=%b id=%0d w=%b e=%h want 1 2 1 1122334455667788", resp_valid, resp_id, resp_isw, resp_entry); end
    tick(g);
    req_v = '0;
    @(negedge clk_in);
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_isw !== 1'b0) begin
      bad++; $display("FAIL rd_resp_tag got v=%b id=%0d w=%b want 1 2 0", resp_valid, resp_id, resp_isw); end
    total++; if (resp_entry !== 64'h1122334455667788 || resp_ev !== 1'b1) begin
      bad++; $display("FAIL rd_resp_data got e=%h ev=%b want 1122334455667788 1", resp_entry, resp_ev); end
    tick(g);
    @(negedge clk_in);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rd_resp_drain got=%b want=0", resp_valid); end
  endtask

  task automatic test_round_robin();
    int g;
    reset_in = 1'b1; tick(g); reset_in = 1'b0;
    resp_ready = 1'b1; req_v = '1;
    for (int i = 0; i < N; i++) begin req_mask[i] = '0; req_addr[i] = 6'd5; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      total++; if (ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        total++; if (resp_id !== 2'((k - 1) % 4)) begin
          bad++; $display("FAIL rr_resp_id k=%0d got=%0d want=%0d", k, resp_id, (k - 1) % 4); end
      end
      tick(g);
    end
  endtask

  task automatic test_backpressure();
    int g;
    @(negedge clk_in);
    total++; if (ready !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b want=0010", ready); end
    tick(g);
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      total++; if (ready !== 4'b0000 || ram_access_en !== 1'b0) begin
        bad++; $display("FAIL bp_stall k=%0d got ready=%b en=%b want 0000 0", k, ready, ram_access_en); end
      total++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_isw !== 1'b0 ||
                   resp_entry !== 64'h1122334455667788 || resp_ev !== 1'b1) begin
        bad++; $display("FAIL bp_hold k=%0d got v=%b id=%0d w=%b e=%h ev=%b want 1 1 0 1122334455667788 1",
                        k, resp_valid, resp_id, resp_isw, resp_entry, resp_ev); end
      tick(g);
    end
    resp_ready = 1'b1;
    @(negedge clk_in);
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL bp_drain_issue got=%b want=0100", ready); end
    tick(g);
    req_v = '0; tick(g);
  endtask

  task automatic test_wrap();
    int g;
    reset_in = 1'b1; tick(g); reset_in = 1'b0;
    req_v = 4'b0001;
    @(negedge clk_in);
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL wrap_g0 got=%b want=0001", ready); end
    tick(g);
    req_v = 4'b1000;
    @(negedge clk_in);
    total++; if (ready !== 4'b1000) begin bad++; $display("FAIL wrap_g3 got=%b want=1000", ready); end
    tick(g);
    req_v = 4'b1111;
    @(negedge clk_in);
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL wrap_ptr0 got=%b want=0001", ready); end
    tick(g);
    req_v = '0; tick(g);
  endtask

  task automatic test_reset_mid();
    int g;
    req_v = 4'b0010;
    @(negedge clk_in);
    total++; if (ready !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b want=0010", ready); end
    tick(g);
    reset_in = 1'b1; req_v = 4'b1111;
    @(negedge clk_in);
    total++; if (ready !== 4'b0000 || ram_access_en !== 1'b0) begin
      bad++; $display("FAIL rmid_in_reset got ready=%b en=%b want 0000 0", ready, ram_access_en); end
    tick(g);
    reset_in = 1'b0;
    @(negedge clk_in);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_dropped got=%b want=0", resp_valid); end
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b want=0001", ready); end
    tick(g);
    req_v = '0; tick(g);
  endtask

  task automatic test_random();
    int g, g2;
    logic [N-1:0] er;
    g2 = -1;
    req_v = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] || g2 == i) begin
          req_v[i]    = ($urandom_range(0, 99) < 60);
          req_mask[i] = ($urandom_range(0, 99) < 35) ? 8'h00 : 8'($urandom);
          req_addr[i] = 6'($urandom_range(0, 7));
          req_data[i] = {$urandom, $urandom};
        end
      end
      resp_ready = ($urandom_range(0, 99) < 70);
      g = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      @(negedge clk_in);
      total++; if (ready !== er || ram_access_en !== (g >= 0)) begin
        bad++; $display("FAIL rnd_grant cyc=%0d got ready=%b en=%b want %b %b", cyc, ready, ram_access_en, er, g >= 0); end
      if (g >= 0) begin
        total++; if (ram_we !== req_mask[g] || ram_addr !== req_addr[g] ||
                     (req_mask[g] != 0 && ram_wdata !== req_data[g])) begin
          bad++; $display("FAIL rnd_ram cyc=%0d got we=%h a=%0d d=%h want %h %0d %h",
                          cyc, ram_we, ram_addr, ram_wdata, req_mask[g], req_addr[g], req_data[g]); end
      end
      total++; if (resp_valid !== m_rv) begin
        bad++; $display("FAIL rnd_resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, m_rv); end
      if (m_rv) begin
        total++; if (resp_id !== m_id || resp_isw !== m_isw || resp_entry !== m_entry || resp_ev !== m_ev) begin
          bad++; $display("FAIL rnd_resp cyc=%0d got id=%0d w=%b e=%h ev=%b want %0d %b %h %b",
                          cyc, resp_id, resp_isw, resp_entry, resp_ev, m_id, m_isw, m_entry, m_ev); end
      end
      tick(g2);
    end
    req_v = '0; resp_ready = 1'b1; tick(g2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1; resp_ready = 1'b1; req_v = '0;
    for (int i = 0; i < N; i++) begin req_mask[i] = '0; req_addr[i] = '0; req_data[i] = '0; end
    test_reset();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
